// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port (sd_clk domain).
// Port 1 (DMA) has fairness-bounded priority over port 0 (CPU); optional counters via SDARB_STATS_EN.
module sdram_wb_arbiter #(
    parameter int MAX_HI  = 4,
    parameter int TIMEOUT = 255,
    parameter int AW      = 24
) (
    input  logic          sd_clk,
    input  logic          reset,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [3:0]    m0_sel,
    input  logic [2:0]    m0_cti,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [3:0]    m1_sel,
    input  logic [2:0]    m1_cti,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [3:0]    s_sel,
    output logic [2:0]    s_cti,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack,
`ifdef SDARB_STATS_EN
    input  logic          stat_clr,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_wait0,
`endif
    output logic [1:0]    gnt
);

    localparam int HW = (MAX_HI  < 1) ? 1 : $clog2(MAX_HI + 1);
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] MAX_HI_C  = HW'(MAX_HI);
    localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hi_cnt_q;
    logic [WW-1:0]   wd_cnt_q;

    logic hi_below_max;
    logic go_g1;
    logic go_g0;
    logic own_cyc;
    logic timeout_hit;

    // Arbitration request decode and watchdog expiry (ack in the same cycle wins).
    always_comb begin
        hi_below_max = (hi_cnt_q < MAX_HI_C);
        go_g1        = (state_q == ST_IDLE) && m1_cyc && (hi_below_max || !m0_cyc);
        go_g0        = (state_q == ST_IDLE) && !go_g1 && m0_cyc;
        if (state_q == ST_G1) begin
            own_cyc = m1_cyc;
        end else if (state_q == ST_G0) begin
            own_cyc = m0_cyc;
        end else begin
            own_cyc = 1'b0;
        end
        timeout_hit = (state_q != ST_IDLE) && (wd_cnt_q == TIMEOUT_C) && !s_ack;
    end

    // Grant FSM with fairness counter and watchdog counter.
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hi_cnt_q <= {HW{1'b0}};
            wd_cnt_q <= {WW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wd_cnt_q <= {WW{1'b0}};
                    if (go_g1) begin
                        state_q <= ST_G1;
                        if (m0_cyc) begin
                            hi_cnt_q <= hi_below_max ? hi_cnt_q + HW'(1) : hi_cnt_q;
                        end else begin
                            hi_cnt_q <= {HW{1'b0}};
                        end
                    end else if (go_g0) begin
                        state_q  <= ST_G0;
                        hi_cnt_q <= {HW{1'b0}};
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_G0, ST_G1: begin
                    if (timeout_hit || !own_cyc) begin
                        state_q  <= ST_IDLE;
                        wd_cnt_q <= {WW{1'b0}};
                    end else if (s_ack) begin
                        wd_cnt_q <= {WW{1'b0}};
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wd_cnt_q <= {WW{1'b0}};
                end
            endcase
        end
    end

    assign gnt = state_q;

    // Slave bus mux: follows whichever master holds the grant, idle otherwise.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = {AW{1'b0}};
        s_sel   = 4'b0000;
        s_cti   = 3'b000;
        s_dat_o = 32'h0000_0000;
        if (state_q == ST_G1) begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_sel   = m1_sel;
            s_cti   = m1_cti;
            s_dat_o = m1_dat_i;
        end else if (state_q == ST_G0) begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_sel   = m0_sel;
            s_cti   = m0_cti;
            s_dat_o = m0_dat_i;
        end else begin
            s_cyc   = 1'b0;
        end
    end

    // Responses reach only the granted master; a reset cycle suppresses them.
    always_comb begin
        m0_ack   = (state_q == ST_G0) && s_ack && !reset;
        m1_ack   = (state_q == ST_G1) && s_ack && !reset;
        m0_err   = (state_q == ST_G0) && timeout_hit && !reset;
        m1_err   = (state_q == ST_G1) && timeout_hit && !reset;
        m0_dat_o = (state_q != ST_IDLE) ? s_dat_i : 32'h0000_0000;
        m1_dat_o = (state_q != ST_IDLE) ? s_dat_i : 32'h0000_0000;
    end

`ifdef SDARB_STATS_EN
    logic [15:0] stat_gnt0_q;
    logic [15:0] stat_gnt1_q;
    logic [15:0] stat_wait0_q;

    // Saturating grant and port-0 wait counters.
    always_ff @(posedge sd_clk) begin
        if (reset || stat_clr) begin
            stat_gnt0_q  <= 16'h0000;
            stat_gnt1_q  <= 16'h0000;
            stat_wait0_q <= 16'h0000;
        end else begin
            if (go_g0 && (stat_gnt0_q != 16'hFFFF)) begin
                stat_gnt0_q <= stat_gnt0_q + 16'h0001;
            end
            if (go_g1 && (stat_gnt1_q != 16'hFFFF)) begin
                stat_gnt1_q <= stat_gnt1_q + 16'h0001;
            end
            if (m0_cyc && (state_q != ST_G0) && (stat_wait0_q != 16'hFFFF)) begin
                stat_wait0_q <= stat_wait0_q + 16'h0001;
            end
        end
    end

    assign stat_gnt0  = stat_gnt0_q;
    assign stat_gnt1  = stat_gnt1_q;
    assign stat_wait0 = stat_wait0_q;
`endif

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: vector table for single transfers plus
// hand sequences for fairness, burst hold, watchdog and reset mid-grant.
module tb_sdram_wb_arbiter;

    localparam int AW = 24;
    localparam logic [AW-1:0] A0 = 24'h000100;
    localparam logic [AW-1:0] A1 = 24'hABCDEF;

    logic          sd_clk = 1'b0;
    logic          reset;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [3:0]    m0_sel;
    logic [2:0]    m0_cti;
    logic [31:0]   m0_dat_i, m0_dat_o;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [3:0]    m1_sel;
    logic [2:0]    m1_cti;
    logic [31:0]   m1_dat_i, m1_dat_o;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [3:0]    s_sel;
    logic [2:0]    s_cti;
    logic [31:0]   s_dat_o, s_dat_i;
    logic          s_ack;
    logic [1:0]    gnt;
`ifdef SDARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_gnt0, stat_gnt1, stat_wait0;
`endif

    int checks   = 0;
    int failures = 0;

    sdram_wb_arbiter #(.MAX_HI(4), .TIMEOUT(8), .AW(AW)) dut (
        .sd_clk(sd_clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_cti(s_cti), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
`ifdef SDARB_STATS_EN
        .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
        .stat_wait0(stat_wait0),
`endif
        .gnt(gnt)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct packed {
        logic          m0c;
        logic          m1c;
        logic          ack;
        logic [31:0]   dat;
        logic [1:0]    e_gnt;
        logic          e_scyc;
        logic [AW-1:0] e_adr;
        logic          e_m0ack;
        logic          e_m1ack;
        logic [31:0]   e_dat;
    } vec_t;

    vec_t vecs [12];
    int   pat  [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic c0, input logic c1, input logic ack, input logic [31:0] dat);
        m0_cyc  = c0;
        m0_stb  = c0;
        m1_cyc  = c1;
        m1_stb  = c1;
        s_ack   = ack;
        s_dat_i = dat;
    endtask

    initial begin
        reset    = 1'b1;
        m0_we    = 1'b0;
        m0_adr   = A0;
        m0_sel   = 4'hF;
        m0_cti   = 3'b000;
        m0_dat_i = 32'h1234_5678;
        m1_we    = 1'b1;
        m1_adr   = A1;
        m1_sel   = 4'h3;
        m1_cti   = 3'b000;
        m1_dat_i = 32'h0BAD_CAFE;
`ifdef SDARB_STATS_EN
        stat_clr = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // m0c m1c ack dat | gnt scyc adr m0ack m1ack dat_o
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF,  2'b01, 1'b1, A0,    1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, A0,    1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, A1,    1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h11112222,  2'b10, 1'b1, A1,    1'b0, 1'b1, 32'h11112222};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         2'b10, 1'b0, A1,    1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hCAFEF00D,  2'b01, 1'b1, A0,    1'b1, 1'b0, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, A0,    1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0};

        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state
        repeat (3) next_cycle();
        reset = 1'b0;
        settle();
        chk("rst_gnt",   {30'h0, gnt}, 32'h0);
        chk("rst_scyc",  {30'h0, s_cyc, s_stb}, 32'h0);
        chk("rst_resp",  {28'h0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
        chk("rst_dat0",  m0_dat_o, 32'h0);
        chk("rst_dat1",  m1_dat_o, 32'h0);
        chk("rst_sadr",  {8'h0, s_adr}, 32'h0);

        // Single read on port 0, then both ports together (port 1 first)
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            drive(vecs[i].m0c, vecs[i].m1c, vecs[i].ack, vecs[i].dat);
            settle();
            chk($sformatf("v%0d_gnt", i),   {30'h0, gnt},       {30'h0, vecs[i].e_gnt});
            chk($sformatf("v%0d_scyc", i),  {31'h0, s_cyc},     {31'h0, vecs[i].e_scyc});
            chk($sformatf("v%0d_sstb", i),  {31'h0, s_stb},     {31'h0, vecs[i].e_scyc});
            chk($sformatf("v%0d_sadr", i),  {8'h0, s_adr},      {8'h0, vecs[i].e_adr});
            chk($sformatf("v%0d_m0ack", i), {31'h0, m0_ack},    {31'h0, vecs[i].e_m0ack});
            chk($sformatf("v%0d_m1ack", i), {31'h0, m1_ack},    {31'h0, vecs[i].e_m1ack});
            chk($sformatf("v%0d_dat0", i),  m0_dat_o,           vecs[i].e_dat);
            chk($sformatf("v%0d_dat1", i),  m1_dat_o,           vecs[i].e_dat);
            chk($sformatf("v%0d_err", i),   {30'h0, m1_err, m0_err}, 32'h0);
        end

        // Fairness: both ports request continuously with single-beat cycles
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            settle();
            chk($sformatf("fair%0d_idle", k), {30'h0, gnt}, 32'h0);
            next_cycle();
            drive(1'b1, 1'b1, 1'b1, 32'h0000_0100 + k);
            settle();
            chk($sformatf("fair%0d_gnt", k), {30'h0, gnt}, (pat[k] == 1) ? 32'h2 : 32'h1);
            chk($sformatf("fair%0d_m1ack", k), {31'h0, m1_ack}, (pat[k] == 1) ? 32'h1 : 32'h0);
            chk($sformatf("fair%0d_m0ack", k), {31'h0, m0_ack}, (pat[k] == 1) ? 32'h0 : 32'h1);
            next_cycle();
            if (pat[k] == 1) drive(1'b1, 1'b0, 1'b0, 32'h0);
            else             drive(1'b0, 1'b1, 1'b0, 32'h0);
            settle();
            chk($sformatf("fair%0d_hold", k), {30'h0, gnt}, (pat[k] == 1) ? 32'h2 : 32'h1);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("fair_end_gnt", {30'h0, gnt}, 32'h0);

        // Port-1 burst: 3 x cti=010 then 111, port 0 asks in the middle
        next_cycle();
        m1_cti = 3'b010;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("bst_idle", {30'h0, gnt}, 32'h0);
        for (int b = 0; b < 5; b++) begin
            next_cycle();
            if (b == 4) m1_cti = 3'b111;
            drive(1'b1, 1'b1, (b != 2), 32'hB000_0000 + b);
            settle();
            chk($sformatf("bst%0d_gnt", b),   {30'h0, gnt}, 32'h2);
            chk($sformatf("bst%0d_m1ack", b), {31'h0, m1_ack}, (b != 2) ? 32'h1 : 32'h0);
            chk($sformatf("bst%0d_m0ack", b), {31'h0, m0_ack}, 32'h0);
            chk($sformatf("bst%0d_cti", b),   {29'h0, s_cti}, (b == 4) ? 32'h7 : 32'h2);
        end
        chk("bst_we",   {31'h0, s_we}, 32'h1);
        chk("bst_wdat", s_dat_o, 32'h0BAD_CAFE);
        chk("bst_sel",  {28'h0, s_sel}, 32'h3);
        next_cycle();
        m1_cti = 3'b000;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        chk("bst_rel_gnt", {30'h0, gnt}, 32'h2);
        next_cycle();
        settle();
        chk("bst_rel_idle", {30'h0, gnt}, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'h5A5A_5A5A);
        settle();
        chk("bst_m0_gnt", {30'h0, gnt}, 32'h1);
        chk("bst_m0_ack", {31'h0, m0_ack}, 32'h1);
        chk("bst_m0_we",  {31'h0, s_we}, 32'h0);
        chk("bst_m0_sel", {28'h0, s_sel}, 32'hF);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        next_cycle();
        settle();
        chk("bst_done", {30'h0, gnt}, 32'h0);

        // Watchdog: no ack ever, err on the cycle wd_cnt reaches TIMEOUT=8
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        for (int g = 0; g <= 8; g++) begin
            next_cycle();
            settle();
            chk($sformatf("wd%0d_gnt", g),  {30'h0, gnt}, 32'h1);
            chk($sformatf("wd%0d_err", g),  {31'h0, m0_err}, (g == 8) ? 32'h1 : 32'h0);
            chk($sformatf("wd%0d_m1err", g), {31'h0, m1_err}, 32'h0);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("wd_after_gnt",  {30'h0, gnt}, 32'h0);
        chk("wd_after_scyc", {31'h0, s_cyc}, 32'h0);
        chk("wd_after_err",  {31'h0, m0_err}, 32'h0);

        // Ack on the timeout cycle wins: no err, grant kept
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        for (int g = 0; g <= 8; g++) begin
            next_cycle();
            drive(1'b1, 1'b0, (g == 8), 32'h0);
            settle();
            chk($sformatf("aw%0d_err", g), {31'h0, m0_err}, 32'h0);
            chk($sformatf("aw%0d_ack", g), {31'h0, m0_ack}, (g == 8) ? 32'h1 : 32'h0);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("aw_hold_gnt", {30'h0, gnt}, 32'h1);
        chk("aw_hold_err", {31'h0, m0_err}, 32'h0);
        next_cycle();
        settle();
        chk("aw_idle_gnt", {30'h0, gnt}, 32'h0);

        // Reset while port 1 holds the grant
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        next_cycle();
        settle();
        chk("rg_gnt", {30'h0, gnt}, 32'h2);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'h7777_7777);
        settle();
        chk("rg_rst_resp", {30'h0, m1_ack, m1_err}, 32'h0);
        next_cycle();
        reset = 1'b0;
        settle();
        chk("rg_post_gnt",  {30'h0, gnt}, 32'h0);
        chk("rg_post_scyc", {31'h0, s_cyc}, 32'h0);
        chk("rg_post_resp", {30'h0, m1_ack, m1_err}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("rg_rearb_gnt", {30'h0, gnt}, 32'h2);
        next_cycle();
        settle();
        chk("rg_end_gnt", {30'h0, gnt}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Two-master Wishbone arbiter directly upstream of the SDRAM controller's Wishbone slave port.
- Merges CPU traffic (port 0) and video/sound DMA traffic (port 1) onto the single slave bus.
- Runs in sd_clk, so the controller's wb_clk is tied to sd_clk.
- Port 1 has priority, bounded by a fairness counter; a watchdog aborts hung cycles.

Parameters:
- MAX_HI, 4, max consecutive port-1 grants while port 0 is waiting; then port 0 wins the next arbitration.
- TIMEOUT, 255, sd_clk cycles a granted cycle may wait for ack before abort.
- AW, 24, address width.

Ports:
- sd_clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_cyc/m0_stb/m0_we  in  1 each  port 0 (CPU) bus
- m0_adr  in  AW  port 0 address
- m0_sel  in  4  port 0 byte selects
- m0_cti  in  3  port 0 cycle type
- m0_dat_i  in  32  port 0 write data
- m0_dat_o  out  32  port 0 read data
- m0_ack/m0_err  out  1 each  port 0 responses
- m1_*  same set as m0_*  port 1 (DMA)
- s_cyc/s_stb/s_we  out  1 each  to SDRAM controller
- s_adr  out  AW  to controller
- s_sel  out  4  to controller
- s_cti  out  3  to controller
- s_dat_o  out  32  to controller
- s_dat_i  in  32  read data from controller
- s_ack  in  1  ack from controller
- gnt  out  2  one-hot current grant (debug)

Behaviour:
- Reset values:
  - state=IDLE, gnt=00, hi_cnt=0, wd_cnt=0.
  - All m*_ack, m*_err, s_cyc, s_stb = 0; data outputs = 0.
- States:
  - IDLE: no grant; slave bus driven idle (cyc/stb=0, other fields 0).
  - G0 / G1: grant to port 0 / port 1.
- Arbitration, in IDLE only, registered:
  - If m1_cyc and (hi_cnt<MAX_HI or !m0_cyc) → G1.
  - Else if m0_cyc → G0.
  - Latency: a request asserted in cycle N reaches s_cyc/s_stb in cycle N+1.
- Grant routing (combinational from gnt):
  - s_* follow the granted master; s_dat_i fans to both m*_dat_o.
  - Only the granted master sees s_ack as m*_ack.
  - Ungranted master: ack=0, err=0, stalls.
- Grant release:
  - Leave G0/G1 → IDLE on the cycle after the granted master deasserts cyc.
  - Burst: cti=010 holds grant across consecutive acks; release only when cyc drops (normally after the cti=111 beat).
  - No re-arbitration while a grant is held, even if the other port is requesting.
- hi_cnt:
  - Increments when entering G1 with m0_cyc=1.
  - Clears on entering G0, or on entering G1 with m0_cyc=0.
  - Saturates at MAX_HI.
- Watchdog:
  - wd_cnt clears on any s_ack or in IDLE; increments each cycle in G0/G1 otherwise.
  - At wd_cnt==TIMEOUT: pulse m*_err for one cycle to the granted master, force s_cyc/s_stb=0, go to IDLE.
  - After an abort the master must drop cyc; if it still holds cyc, it is re-arbitrated normally.
- Simultaneous events:
  - s_ack in the same cycle the master drops cyc: ack is still delivered.
  - Timeout and s_ack in the same cycle: ack wins, no err.
- Reset mid-grant: grant drops next cycle, no ack or err is generated.
- Acks from the controller are single-cycle pulses and are passed through unmodified.

Optional Feature:
- Macro SDARB_STATS_EN.
- With it defined:
  - Adds outputs stat_gnt0, stat_gnt1, stat_wait0 (16 bit each, saturating).
  - Counts grants to each port, and sd_clk cycles port 0 spent requesting without grant.
  - All three cleared by reset and by input stat_clr (1 bit).
- Without it: no such ports or logic; behaviour otherwise identical.

Test Plan:
- Single read, port 0 only, m0_adr=0x000100: s_cyc rises the cycle after m0_cyc; on s_ack with s_dat_i=0xDEADBEEF → m0_ack=1, m0_dat_o=0xDEADBEEF; gnt returns to 00 the cycle after m0_cyc drops.
- Both ports request in the same cycle → G1 granted first; m0 stalls with ack=0 until m1 drops cyc, then G0.
- Fairness with MAX_HI=4: m0 and m1 request continuously with single-beat cycles → grant pattern 1,1,1,1,0,1,1,1,1,0.
- Port-1 burst, cti=010 for 3 beats then 111: grant held for all 4 acks; m0 request during the burst is not granted until after release.
- Watchdog with TIMEOUT=8: s_ack never asserted → m0_err pulses exactly at the 8th wait cycle, s_cyc=0 next cycle, state IDLE.
- Reset asserted during G1 with pending cycle → s_cyc=0 and gnt=00 on the next clock; no m1_ack or m1_err.
